rv32_mmio_uart_tx: RTL



---
 rtl/rv32_mmio_uart_tx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rv32_mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: 16-byte MMIO register window, TX FIFO,
// baud-rate serializer and a drained-FIFO level interrupt.
module rv32_mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0100,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] CLK_DIV    = 16'd868
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_strobe_i,
  output logic        request_done_o,
  output logic [31:0] data_o,
  output logic        tx_o,
  output logic        irq_o,
  output logic [1:0]  state_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_e;

  state_e        state_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          ovf_q, ovf_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [15:0]   div_q, div_d;
  logic          done_q;
  logic [31:0]   data_q, data_d;
  logic [15:0]   baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q, irq_q;

  logic          hit, accept, full, empty, push, push_ok, pop;
  logic [1:0]    sel;
  logic [15:0]   divisor, reload;
  logic [31:0]   status;
  logic          unused_ok;

  // Handshake: a window hit is taken only while done_q is low; done_q then pulses
  // for one cycle and any request still presented during that pulse is ignored.
  assign hit     = req_valid_i && (req_addr_i[31:4] == BASE_ADDR[31:4]);
  assign accept  = hit && !done_q;
  assign sel     = req_addr_i[3:2];
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push    = accept && req_write_i && (sel == 2'd0) && req_strobe_i[0];
  assign pop     = (state_q == IDLE) && ctrl_q[0] && !empty;
  assign push_ok = push && (!full || pop);
  assign divisor = (div_q == 16'd0) ? 16'd1 : div_q;
  assign reload  = divisor - 16'd1;
  assign status  = {16'h0, 8'(count_q), 4'h0, ovf_q, (state_q != IDLE), empty, full};
  assign unused_ok = ^{req_wdata_i[31:16], req_addr_i[1:0], req_strobe_i[3:2]};

  always_comb begin
    ctrl_d = ctrl_q;
    div_d  = div_q;
    ovf_d  = ovf_q;
    data_d = data_q;
    if (accept && req_write_i) begin
      case (sel)
        2'd1: if (req_strobe_i[0] && req_wdata_i[3]) ovf_d = 1'b0;
        2'd2: if (req_strobe_i[0]) ctrl_d = req_wdata_i[1:0];
        2'd3: begin
          if (req_strobe_i[0]) div_d[7:0]  = req_wdata_i[7:0];
          if (req_strobe_i[1]) div_d[15:8] = req_wdata_i[15:8];
        end
        default: ;
      endcase
    end else if (accept) begin
      case (sel)
        2'd0:    data_d = 32'h0;
        2'd1:    data_d = status;
        2'd2:    data_d = {30'h0, ctrl_q};
        default: data_d = {16'h0, div_q};
      endcase
    end
    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push_ok) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= req_wdata_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      ctrl_q   <= 2'b00;
      div_q    <= CLK_DIV;
      done_q   <= 1'b0;
      data_q   <= 32'h0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      ctrl_q   <= ctrl_d;
      div_q    <= div_d;
      done_q   <= accept;
      data_q   <= data_d;
    end
  end

  // tx_q is registered alongside state_q, so the line level always matches the state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      baud_q  <= 16'h0;
      bit_q   <= 3'd0;
      shift_q <= 8'h0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b0;
    end else begin
      irq_q <= ctrl_q[1] && empty && (state_q == IDLE);
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            baud_q  <= reload;
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (baud_q == 16'h0) begin
            state_q <= DATA;
            bit_q   <= 3'd0;
            baud_q  <= reload;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        DATA: begin
          if (baud_q == 16'h0) begin
            baud_q <= reload;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        default: begin
          if (baud_q == 16'h0) state_q <= IDLE;
          else                 baud_q  <= baud_q - 16'd1;
        end
      endcase
    end
  end

  assign request_done_o = done_q;
  assign data_o         = data_q;
  assign tx_o           = tx_q;
  assign irq_o          = irq_q;
  assign state_o        = state_q;
endmodule
